// File: rtl/lap_pkg.sv
// Shared types and constants for the lap/split capture stage.
package lap_pkg;

    // Display/FSM mode; encoding is visible on the mode output.
    typedef enum logic [1:0] {
        LIVE   = 2'd0,
        HOLD   = 2'd1,
        RECALL = 2'd2
    } lap_mode_t;

    // One BCD time sample as carried between stopwatch, buffer and display.
    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
        logic [3:0] tenths;
    } bcd_time_t;

    // Digit code the display renders as blank.
    localparam logic [3:0] BLANK_DIGIT = 4'hF;

endpackage

// File: rtl/lap_buffer.sv
// Lap storage: DEPTH x 12-bit register file, synchronous write and
// combinational read. Contents are intentionally not reset.
module lap_buffer
    import lap_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  bcd_time_t                wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output bcd_time_t                rdata
);

    bcd_time_t r_mem [DEPTH];

    // Write one lap entry when the capture logic requests it.
    always_ff @(posedge clk) begin
        if (we) r_mem[waddr] <= wdata;
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/lap_split_capture.sv
// Lap/split stage: synchronises the live BCD bus, captures splits into the
// lap buffer, freezes the display for a hold period and pages stored laps.
module lap_split_capture
    import lap_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int HOLD_CYCLES = 200_000_000
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       lap_pulse,
    input  logic                       recall_pulse,
    input  logic                       clear_pulse,
    input  logic [3:0]                 live_tens,
    input  logic [3:0]                 live_ones,
    input  logic [3:0]                 live_tenths,
    output logic [3:0]                 disp_tens,
    output logic [3:0]                 disp_ones,
    output logic [3:0]                 disp_tenths,
    output logic [3:0]                 disp_aux,
    output logic [1:0]                 mode,
    output logic [$clog2(DEPTH+1)-1:0] lap_count,
    output logic                       lap_full
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(HOLD_CYCLES - 1);

    // Synchroniser and coherent snapshot
    bcd_time_t r_s1, r_s2, r_snap;
    logic      w_coherent;

    // FSM state and its next-state values
    lap_mode_t       r_mode, w_mode_nx;
    logic [CW-1:0]   r_cnt, w_cnt_nx;
    logic [AW-1:0]   r_rd, w_rd_nx;
    logic [TW-1:0]   r_timer, w_timer_nx;
    bcd_time_t       r_hold, w_hold_nx;
    logic            w_we;
    logic            w_last;

    // Output registers
    bcd_time_t  r_disp, w_disp_nx;
    logic [3:0] r_aux, w_aux_nx;
    logic       r_full;
    bcd_time_t  w_rdata;

    // The bus is asynchronous; only take it when two consecutive samples agree,
    // so a digit rollover in flight can never produce a mixed-digit snapshot.
    assign w_coherent = (r_s1 == r_s2);

    // Two-flop sync of the live bus plus coherent snapshot register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_snap <= '0;
        end else begin
            r_s1 <= bcd_time_t'({live_tens, live_ones, live_tenths});
            r_s2 <= r_s1;
            if (w_coherent) r_snap <= r_s2;
        end
    end

    lap_buffer #(.DEPTH(DEPTH)) u_buf (
        .clk   (clk),
        .we    (w_we),
        .waddr (AW'(r_cnt)),
        .wdata (r_snap),
        .raddr (w_rd_nx),
        .rdata (w_rdata)
    );

    assign w_last = ((CW'(r_rd) + CW'(1)) == r_cnt);

    // Next-state: clear beats lap, lap beats recall.
    always_comb begin
        w_mode_nx  = r_mode;
        w_cnt_nx   = r_cnt;
        w_rd_nx    = r_rd;
        w_timer_nx = r_timer;
        w_hold_nx  = r_hold;
        w_we       = 1'b0;
        if (clear_pulse) begin
            w_mode_nx  = LIVE;
            w_cnt_nx   = '0;
            w_rd_nx    = '0;
            w_timer_nx = '0;
        end else begin
            case (r_mode)
                LIVE, HOLD: begin
                    if (lap_pulse) begin
                        // A full buffer still freezes the display, it just stores nothing.
                        if (r_cnt != CNT_FULL) begin
                            w_we     = 1'b1;
                            w_cnt_nx = r_cnt + CW'(1);
                        end
                        w_hold_nx  = r_snap;
                        w_timer_nx = TIMER_LOAD;
                        w_mode_nx  = HOLD;
                    end else if (recall_pulse && (r_cnt != '0)) begin
                        w_rd_nx   = '0;
                        w_mode_nx = RECALL;
                    end else if (r_mode == HOLD) begin
                        if (r_timer == '0) w_mode_nx = LIVE;
                        else               w_timer_nx = r_timer - TW'(1);
                    end
                end
                RECALL: begin
                    if (lap_pulse) begin
                        w_mode_nx = LIVE;
                    end else if (recall_pulse) begin
                        if (w_last) w_mode_nx = LIVE;
                        else        w_rd_nx   = r_rd + AW'(1);
                    end
                end
                default: w_mode_nx = LIVE;
            endcase
        end
    end

    // Display source follows the mode being entered so pulses show up one edge later.
    always_comb begin
        w_disp_nx = r_snap;
        w_aux_nx  = BLANK_DIGIT;
        case (w_mode_nx)
            HOLD:    w_disp_nx = w_hold_nx;
            RECALL: begin
                w_disp_nx = w_rdata;
                w_aux_nx  = 4'(w_rd_nx) + 4'd1;
            end
            default: w_disp_nx = r_snap;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode  <= LIVE;
            r_cnt   <= '0;
            r_rd    <= '0;
            r_timer <= '0;
            r_hold  <= '0;
        end else begin
            r_mode  <= w_mode_nx;
            r_cnt   <= w_cnt_nx;
            r_rd    <= w_rd_nx;
            r_timer <= w_timer_nx;
            r_hold  <= w_hold_nx;
        end
    end

    // Registered outputs toward the display.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_disp <= '0;
            r_aux  <= BLANK_DIGIT;
            r_full <= 1'b0;
        end else begin
            r_disp <= w_disp_nx;
            r_aux  <= w_aux_nx;
            r_full <= (w_cnt_nx == CNT_FULL);
        end
    end

    assign disp_tens   = r_disp.tens;
    assign disp_ones   = r_disp.ones;
    assign disp_tenths = r_disp.tenths;
    assign disp_aux    = r_aux;
    assign mode        = r_mode;
    assign lap_count   = r_cnt;
    assign lap_full    = r_full;

endmodule

// File: doc/lap_split_capture.md
# lap_split_capture

Lap/split-time stage between the stopwatch counter and `seven_seg_display`. It takes the live BCD time, captures split snapshots into an 8-entry lap buffer on a debounced lap pulse, and freezes the display on each split for a hold period. It also lets the user page through stored laps. Its registered outputs drive the display's digit inputs directly.

## Interface
- `DEPTH`, 8: lap buffer entries; must be ≥2.
- `HOLD_CYCLES`, 200_000_000: split-freeze duration in `clk` cycles (2 s at 100 MHz); must be ≥1.
- `clk` in 1: 100 MHz system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `lap_pulse` in 1: single-cycle debounced edge; capture split / exit recall.
- `recall_pulse` in 1: single-cycle debounced edge; enter or advance recall.
- `clear_pulse` in 1: single-cycle; empties the buffer; tied to the stopwatch reset edge.
- `live_tens`, `live_ones`, `live_tenths` in 4 each: BCD time from the stopwatch; asynchronous to `clk`.
- `disp_tens`, `disp_ones`, `disp_tenths` out 4 each: digits sent to the display.
- `disp_aux` out 4: lap number (1..DEPTH) while in RECALL, otherwise 4'hF (blank).
- `mode` out 2: 0 = LIVE, 1 = HOLD, 2 = RECALL.
- `lap_count` out clog2(DEPTH+1): number of stored laps.
- `lap_full` out 1: high when lap_count == DEPTH.

## Operation
- **Input sync:** the 12-bit live bus passes through two flops (s1, s2).
  - A sample is coherent when s1 == s2.
  - `snap` updates from s2 only on coherent cycles; otherwise it keeps its previous value.
  - All captures and the LIVE display use `snap`.
- **Buffer:** linear, not circular. Write index = lap_count; entry 0 is the oldest lap.
- **LIVE:**
  - Display = snap.
  - `lap_pulse`: if not full, write snap to buf[lap_count] and increment lap_count. If full, nothing is written. In both cases: load hold_reg ← snap, load timer ← HOLD_CYCLES-1, go to HOLD.
  - `recall_pulse` with lap_count > 0: rd_idx ← 0, go to RECALL. With lap_count == 0: ignored.
- **HOLD:**
  - Display = hold_reg.
  - Timer decrements every cycle. At timer == 0, go to LIVE.
  - `lap_pulse`: same capture as in LIVE; the timer restarts.
  - `recall_pulse`: same as in LIVE.
- **RECALL:**
  - Display = buf[rd_idx]; disp_aux = rd_idx+1.
  - `recall_pulse`: if rd_idx == lap_count-1, go to LIVE; otherwise rd_idx increments.
  - `lap_pulse`: go to LIVE with no capture.
- **Clear:** `clear_pulse` in any state sets lap_count ← 0, rd_idx ← 0, timer ← 0, mode ← LIVE. Buffer contents are don't-care afterwards.
- **Priority** for same-cycle events: clear > lap > recall.
- **Counter behaviour:** lap_count saturates at DEPTH and never wraps. rd_idx never exceeds lap_count-1.

## Timing
- **Reset (reset_n low, asynchronous):**
  - All disp_* = 0, disp_aux = 4'hF, mode = LIVE.
  - lap_count = 0, lap_full = 0, snap/s1/s2/hold_reg/timer = 0.
  - Buffer is not reset.
  - Release is synchronous to `clk`.
  - Reset asserted mid-HOLD or mid-RECALL returns the block to LIVE immediately.
- **Live path latency:** a stable input change appears on disp_* 4 cycles later: s1, s2, snap, output register.
- **Pulse response:** all outputs are registered. A pulse at edge N changes mode, lap_count and lap_full at edge N+1, and disp_* also at N+1 (from hold_reg / buf data).
- **HOLD duration:** exactly HOLD_CYCLES cycles in HOLD, counted from the capture edge, when no further lap arrives.
- **Input pulse spacing:** pulses are single-cycle and may arrive on back-to-back cycles; each one is acted on.

## Structure
- **Package `lap_pkg`:**
  - mode enum `lap_mode_t` (LIVE, HOLD, RECALL);
  - `bcd_time_t` struct (tens, ones, tenths, 4 bits each);
  - `BLANK_DIGIT` = 4'hF.
- **Sub-module `lap_buffer`:**
  - DEPTH × 12-bit register array;
  - synchronous write port (we, waddr, wdata);
  - combinational read port (raddr → rdata).
- The top level holds the sync/coherence logic, FSM, hold timer and output registers.

## Test plan
- Reset, then drive live 1/2/3 stable → disp_* = 1,2,3 four cycles later; mode 0, disp_aux F, lap_count 0.
- HOLD_CYCLES = 10, live 0,4,7, lap_pulse → mode 1 next edge, disp 0,4,7 while live advances to 0,5,2; back to LIVE after exactly 10 cycles; lap_count = 1.
- 9 lap_pulses with distinct times → lap_count saturates at 8, lap_full = 1; the 9th time is held on display but not stored; recall pulses step disp_aux 1..8 showing laps 1..8, and the 9th recall returns to LIVE.
- recall_pulse with lap_count = 0 → stays LIVE. Same-cycle lap+recall in LIVE → capture wins (mode HOLD). Same-cycle clear+lap → lap_count 0, mode LIVE.
- Live bus toggling every cycle (s1 ≠ s2) during lap_pulse → captured value equals the last coherent snap, never a mixed-digit value.
- reset_n pulsed low mid-RECALL (asynchronous, between clock edges) → outputs reach reset values without waiting for a clock edge; lap_count = 0.
